// File: rtl/reaction_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reaction_pkg                                                    |
// | Purpose  : Shared types and constants for the reaction-time benchmark.     |
// |            Holds the session FSM encoding, the screen codes used by the    |
// |            datapath and VGA renderer, and the running-sum width rule.      |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package reaction_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ARM     = 4'd1,
    S_WAIT    = 4'd2,
    S_GO      = 4'd3,
    S_CAPTURE = 4'd4,
    S_RESULT  = 4'd5,
    S_FOUL    = 4'd6,
    S_DIV     = 4'd7,
    S_SUMMARY = 4'd8
  } state_e;

  localparam logic [2:0] SCR_MENU    = 3'd0;
  localparam logic [2:0] SCR_WAIT    = 3'd1;
  localparam logic [2:0] SCR_GO      = 3'd2;
  localparam logic [2:0] SCR_RESULT  = 3'd3;
  localparam logic [2:0] SCR_FOUL    = 3'd4;
  localparam logic [2:0] SCR_SUMMARY = 3'd5;

  // At most 7 rounds are summed, so 3 extra bits always hold the total.
  localparam int SUM_EXTRA_W = 3;

  function automatic int sum_width(input int score_w);
    return score_w + SUM_EXTRA_W;
  endfunction

  // CAPTURE shows RESULT because the score is frozen by then; DIV keeps the
  // last round's result on screen until the average is ready.
  function automatic logic [2:0] screen_of(input state_e s);
    logic [2:0] scr;
    scr = SCR_MENU;
    case (s)
      S_IDLE:    scr = SCR_MENU;
      S_ARM,
      S_WAIT:    scr = SCR_WAIT;
      S_GO:      scr = SCR_GO;
      S_CAPTURE,
      S_RESULT,
      S_DIV:     scr = SCR_RESULT;
      S_FOUL:    scr = SCR_FOUL;
      S_SUMMARY: scr = SCR_SUMMARY;
      default:   scr = SCR_MENU;
    endcase
    return scr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_divider                                                     |
// | Purpose  : Restoring divider, one quotient bit per clock. The start cycle  |
// |            already produces the first bit, so done_o rises DIVIDEND_W      |
// |            edges after start_i is sampled-high edge minus one, i.e. the    |
// |            result is ready DIVIDEND_W cycles after start.                  |
// | Ports    : clk, iResetn (async, active-low)                                |
// |            start_i     in  1           begin a division (restarts if busy) |
// |            dividend_i  in  DIVIDEND_W                                      |
// |            divisor_i   in  DIVISOR_W   must be non-zero                    |
// |            quotient_o  out DIVIDEND_W  valid while done_o is high          |
// |            done_o      out 1           one-cycle completion pulse          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seq_divider #(
  parameter int DIVIDEND_W = 15,
  parameter int DIVISOR_W  = 3
) (
  input  logic                  clk,
  input  logic                  iResetn,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic                  done_o
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] quo_q, quo_d, quo_in;
  logic [DIVISOR_W-1:0]  rem_q, rem_d, rem_in;
  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W:0]    divisor_ext;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    // The quotient register doubles as the dividend shift register.
    rem_in      = start_i ? '0 : rem_q;
    quo_in      = start_i ? dividend_i : quo_q;
    trial       = {rem_in, quo_in[DIVIDEND_W-1]};
    divisor_ext = {1'b0, divisor_i};

    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (start_i || busy_q) begin
      if (trial >= divisor_ext) begin
        rem_d = DIVISOR_W'(trial - divisor_ext);
        quo_d = {quo_in[DIVIDEND_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DIVISOR_W-1:0];
        quo_d = {quo_in[DIVIDEND_W-2:0], 1'b0};
      end
      cnt_d = start_i ? CNT_W'(1) : cnt_q + 1'b1;
      if (cnt_d == CNT_W'(DIVIDEND_W)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = done_q;

endmodule
`default_nettype wire

// File: rtl/reaction_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reaction_session_ctrl                                           |
// | Purpose  : Multi-round session sequencer for the reaction-time benchmark.  |
// |            Drives the datapath counters, detects false starts, tracks the  |
// |            best score and computes the truncated session average.          |
// | Ports    : clk, iResetn (async, active-low)                                |
// |            iSpacePressed, iOnePressed  key pulses                          |
// |            iPrng[7:0], iCountComplete, iRoundScore[SCORE_W-1:0]            |
// |            oDelayLoad[7:0], oStartDownCount, oStartUpCount, oLoadScore     |
// |            oScreen[2:0], oRound[2:0], oFouls[3:0]                          |
// |            oBest, oAverage [SCORE_W-1:0], oValid                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module reaction_session_ctrl
  import reaction_pkg::*;
#(
  parameter int NUM_ROUNDS = 5,
  parameter int SCORE_W    = 12,
  parameter int TIMEOUT_MS = 999
) (
  input  logic               clk,
  input  logic               iResetn,
  input  logic               iSpacePressed,
  input  logic               iOnePressed,
  input  logic [7:0]         iPrng,
  input  logic               iCountComplete,
  input  logic [SCORE_W-1:0] iRoundScore,
  output logic [7:0]         oDelayLoad,
  output logic               oStartDownCount,
  output logic               oStartUpCount,
  output logic               oLoadScore,
  output logic [2:0]         oScreen,
  output logic [2:0]         oRound,
  output logic [3:0]         oFouls,
  output logic [SCORE_W-1:0] oBest,
  output logic [SCORE_W-1:0] oAverage,
  output logic               oValid
);

  localparam int                 SUM_W      = sum_width(SCORE_W);
  localparam logic [SCORE_W-1:0] TIMEOUT_C  = SCORE_W'(TIMEOUT_MS);
  localparam logic [2:0]         LAST_ROUND = 3'(NUM_ROUNDS - 1);
  localparam logic [2:0]         DIVISOR_C  = 3'(NUM_ROUNDS);

  state_e             state_q, state_d;
  logic [7:0]         delay_q, delay_d;
  logic               down_q, down_d;
  logic               up_q, up_d;
  logic               load_q, load_d;
  logic               div_start_q, div_start_d;
  logic [2:0]         screen_q;
  logic [2:0]         round_q, round_d;
  logic [3:0]         fouls_q, fouls_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [SCORE_W-1:0] avg_q, avg_d;
  logic               valid_q, valid_d;
  logic [SUM_W-1:0]   sum_q, sum_d;

  logic [SCORE_W-1:0] sample;
  logic [SUM_W-1:0]   quot;
  logic               div_done;
  logic               abort;

  assign sample = (iRoundScore > TIMEOUT_C) ? TIMEOUT_C : iRoundScore;

  always_comb begin
    abort = 1'b0;
    case (state_q)
      S_ARM, S_WAIT, S_GO, S_CAPTURE, S_RESULT, S_FOUL, S_DIV: abort = iOnePressed;
      default:                                                abort = 1'b0;
    endcase
  end

  seq_divider #(
    .DIVIDEND_W(SUM_W),
    .DIVISOR_W (3)
  ) u_div (
    .clk       (clk),
    .iResetn   (iResetn),
    .start_i   (div_start_q),
    .dividend_i(sum_q),
    .divisor_i (DIVISOR_C),
    .quotient_o(quot),
    .done_o    (div_done)
  );

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    down_d      = 1'b0;
    up_d        = 1'b0;
    load_d      = 1'b0;
    div_start_d = 1'b0;
    round_d     = round_q;
    fouls_d     = fouls_q;
    best_d      = best_q;
    avg_d       = avg_q;
    valid_d     = valid_q;
    sum_d       = sum_q;

    if (abort) begin
      // Nothing is committed; any divide still running is simply ignored
      // because its done pulse is only honoured in DIV.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iSpacePressed) begin
            sum_d   = '0;
            round_d = '0;
            fouls_d = '0;
            best_d  = '0;
            avg_d   = '0;
            valid_d = 1'b0;
            state_d = S_ARM;
          end
        end
        S_ARM: begin
          delay_d = iPrng;
          down_d  = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // A press in the same cycle as the delay expiring is still early.
          if (iSpacePressed) begin
            fouls_d = (fouls_q == 4'hF) ? fouls_q : fouls_q + 4'd1;
            state_d = S_FOUL;
          end else if (iCountComplete) begin
            up_d    = 1'b1;
            state_d = S_GO;
          end
        end
        S_GO: begin
          if (iSpacePressed || (iRoundScore >= TIMEOUT_C)) begin
            load_d  = 1'b1;
            state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          sum_d   = sum_q + SUM_W'(sample);
          best_d  = ((round_q == 3'd0) || (sample < best_q)) ? sample : best_q;
          state_d = S_RESULT;
        end
        S_RESULT: begin
          if (iSpacePressed) begin
            if (round_q == LAST_ROUND) begin
              div_start_d = 1'b1;
              state_d     = S_DIV;
            end else begin
              round_d = round_q + 3'd1;
              state_d = S_ARM;
            end
          end
        end
        S_FOUL: begin
          if (iSpacePressed) begin
            state_d = S_ARM;
          end
        end
        S_DIV: begin
          if (div_done) begin
            // Upper quotient bits are zero whenever samples are clamped;
            // saturate rather than wrap if that ever stops holding.
            avg_d   = (|quot[SUM_W-1:SCORE_W]) ? '1 : quot[SCORE_W-1:0];
            valid_d = 1'b1;
            state_d = S_SUMMARY;
          end
        end
        S_SUMMARY: begin
          if (iSpacePressed || iOnePressed) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state_q     <= S_IDLE;
      delay_q     <= '0;
      down_q      <= 1'b0;
      up_q        <= 1'b0;
      load_q      <= 1'b0;
      div_start_q <= 1'b0;
      screen_q    <= SCR_MENU;
      round_q     <= '0;
      fouls_q     <= '0;
      best_q      <= '0;
      avg_q       <= '0;
      valid_q     <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      down_q      <= down_d;
      up_q        <= up_d;
      load_q      <= load_d;
      div_start_q <= div_start_d;
      screen_q    <= screen_of(state_d);
      round_q     <= round_d;
      fouls_q     <= fouls_d;
      best_q      <= best_d;
      avg_q       <= avg_d;
      valid_q     <= valid_d;
      sum_q       <= sum_d;
    end
  end

  assign oDelayLoad      = delay_q;
  assign oStartDownCount = down_q;
  assign oStartUpCount   = up_q;
  assign oLoadScore      = load_q;
  assign oScreen         = screen_q;
  assign oRound          = round_q;
  assign oFouls          = fouls_q;
  assign oBest           = best_q;
  assign oAverage        = avg_q;
  assign oValid          = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_reaction_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_reaction_session_ctrl                                        |
// | Purpose  : Self-checking bench for reaction_session_ctrl: a cycle-by-cycle |
// |            vector table for the first rounds, then directed sessions for   |
// |            averaging, false starts, timeout, abort and mid-session reset.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_reaction_session_ctrl;

  localparam int SCORE_W = 12;
  localparam int SUM_W   = SCORE_W + 3;

  logic               clk = 1'b0;
  logic               iResetn = 1'b0;
  logic               iSpacePressed = 1'b0;
  logic               iOnePressed = 1'b0;
  logic [7:0]         iPrng = 8'hA5;
  logic               iCountComplete = 1'b0;
  logic [SCORE_W-1:0] iRoundScore = '0;
  logic [7:0]         oDelayLoad;
  logic               oStartDownCount, oStartUpCount, oLoadScore;
  logic [2:0]         oScreen, oRound;
  logic [3:0]         oFouls;
  logic [SCORE_W-1:0] oBest, oAverage;
  logic               oValid;

  int n_cmp = 0;
  int n_bad = 0;

  reaction_session_ctrl #(.NUM_ROUNDS(5), .SCORE_W(SCORE_W), .TIMEOUT_MS(999)) dut (
    .clk            (clk),
    .iResetn        (iResetn),
    .iSpacePressed  (iSpacePressed),
    .iOnePressed    (iOnePressed),
    .iPrng          (iPrng),
    .iCountComplete (iCountComplete),
    .iRoundScore    (iRoundScore),
    .oDelayLoad     (oDelayLoad),
    .oStartDownCount(oStartDownCount),
    .oStartUpCount  (oStartUpCount),
    .oLoadScore     (oLoadScore),
    .oScreen        (oScreen),
    .oRound         (oRound),
    .oFouls         (oFouls),
    .oBest          (oBest),
    .oAverage       (oAverage),
    .oValid         (oValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               sp;
    logic               cc;
    logic [SCORE_W-1:0] score;
    logic [2:0]         scr;
    logic [2:0]         rnd;
    logic [3:0]         fouls;
    logic               down;
    logic               up;
    logic               ld;
    logic [7:0]         dload;
    logic [SCORE_W-1:0] best;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic sp, input logic cc, input int score,
                              input int scr, input int rnd, input int fouls,
                              input logic down, input logic up, input logic ld,
                              input int dload, input int best);
    vec_t v;
    v.sp = sp; v.cc = cc; v.score = SCORE_W'(score);
    v.scr = 3'(scr); v.rnd = 3'(rnd); v.fouls = 4'(fouls);
    v.down = down; v.up = up; v.ld = ld;
    v.dload = 8'(dload); v.best = SCORE_W'(best);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_space();
    iSpacePressed = 1'b1;
    tick();
    iSpacePressed = 1'b0;
  endtask

  // Starts with ARM registered, ends with RESULT registered.
  task automatic play_round(input int score);
    tick();                                   // -> WAIT
    iCountComplete = 1'b1; tick(); iCountComplete = 1'b0;   // -> GO
    press_space();                            // -> CAPTURE
    iRoundScore = SCORE_W'(score); tick();    // -> RESULT, sample taken
    iRoundScore = '0;
  endtask

  // Space just taken into DIV; checks the exact latency of oValid.
  task automatic wait_average(input string tag);
    for (int i = 0; i < SUM_W; i++) tick();
    chk({tag, "_valid_early"}, int'(oValid), 0);
    tick();
    chk({tag, "_valid"}, int'(oValid), 1);
    chk({tag, "_screen"}, int'(oScreen), 5);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_screen", int'(oScreen), 0);
    chk("rst_valid", int'(oValid), 0);
    chk("rst_down", int'(oStartDownCount), 0);
    @(negedge clk);
    iResetn = 1'b1;
    tick();
    chk("rst_round", int'(oRound), 0);
    chk("rst_best", int'(oBest), 0);

    // Round 0 scored 200, round 1 starts with a simultaneous space/count
    // event (foul, no up-count pulse), retry scores 1200 which clamps to 999.
    vecs[0]  = mk(1, 0,    0, 1, 0, 0, 0, 0, 0, 8'h00,   0);
    vecs[1]  = mk(0, 0,    0, 1, 0, 0, 1, 0, 0, 8'hA5,   0);
    vecs[2]  = mk(0, 0,    0, 1, 0, 0, 0, 0, 0, 8'hA5,   0);
    vecs[3]  = mk(0, 1,    0, 2, 0, 0, 0, 1, 0, 8'hA5,   0);
    vecs[4]  = mk(0, 0,  100, 2, 0, 0, 0, 0, 0, 8'hA5,   0);
    vecs[5]  = mk(1, 0,  150, 3, 0, 0, 0, 0, 1, 8'hA5,   0);
    vecs[6]  = mk(0, 0,  200, 3, 0, 0, 0, 0, 0, 8'hA5, 200);
    vecs[7]  = mk(0, 0,    0, 3, 0, 0, 0, 0, 0, 8'hA5, 200);
    vecs[8]  = mk(1, 0,    0, 1, 1, 0, 0, 0, 0, 8'hA5, 200);
    vecs[9]  = mk(0, 0,    0, 1, 1, 0, 1, 0, 0, 8'hA5, 200);
    vecs[10] = mk(1, 1,    0, 4, 1, 1, 0, 0, 0, 8'hA5, 200);
    vecs[11] = mk(0, 0,    0, 4, 1, 1, 0, 0, 0, 8'hA5, 200);
    vecs[12] = mk(1, 0,    0, 1, 1, 1, 0, 0, 0, 8'hA5, 200);
    vecs[13] = mk(0, 0,    0, 1, 1, 1, 1, 0, 0, 8'hA5, 200);
    vecs[14] = mk(0, 1,    0, 2, 1, 1, 0, 1, 0, 8'hA5, 200);
    vecs[15] = mk(1, 0,    0, 3, 1, 1, 0, 0, 1, 8'hA5, 200);
    vecs[16] = mk(0, 0, 1200, 3, 1, 1, 0, 0, 0, 8'hA5, 200);

    for (int i = 0; i < 17; i++) begin
      iSpacePressed  = vecs[i].sp;
      iCountComplete = vecs[i].cc;
      iRoundScore    = vecs[i].score;
      tick();
      chk($sformatf("v%0d_screen", i), int'(oScreen), int'(vecs[i].scr));
      chk($sformatf("v%0d_round", i), int'(oRound), int'(vecs[i].rnd));
      chk($sformatf("v%0d_fouls", i), int'(oFouls), int'(vecs[i].fouls));
      chk($sformatf("v%0d_down", i), int'(oStartDownCount), int'(vecs[i].down));
      chk($sformatf("v%0d_up", i), int'(oStartUpCount), int'(vecs[i].up));
      chk($sformatf("v%0d_load", i), int'(oLoadScore), int'(vecs[i].ld));
      chk($sformatf("v%0d_dload", i), int'(oDelayLoad), int'(vecs[i].dload));
      chk($sformatf("v%0d_best", i), int'(oBest), int'(vecs[i].best));
      chk($sformatf("v%0d_valid", i), int'(oValid), 0);
    end
    iSpacePressed = 1'b0; iCountComplete = 1'b0; iRoundScore = '0;

    // Finish that session: (200 + 999 + 300*3) / 5 = 419
    for (int r = 2; r < 5; r++) begin
      press_space();
      play_round(300);
    end
    press_space();
    wait_average("clamp");
    chk("clamp_avg", int'(oAverage), 419);
    chk("clamp_best", int'(oBest), 200);
    chk("clamp_fouls", int'(oFouls), 1);

    // Clean session: 200,250,300,180,220 -> best 180, avg 230
    press_space();
    chk("sum_to_menu", int'(oScreen), 0);
    press_space();
    chk("clean_start_valid", int'(oValid), 0);
    chk("clean_start_fouls", int'(oFouls), 0);
    play_round(200); press_space();
    play_round(250); press_space();
    play_round(300); press_space();
    play_round(180); press_space();
    play_round(220);
    chk("clean_last_round", int'(oRound), 4);
    press_space();
    wait_average("clean");
    chk("clean_best", int'(oBest), 180);
    chk("clean_avg", int'(oAverage), 230);
    chk("clean_fouls", int'(oFouls), 0);

    // False start in round 2, all scores 300 -> avg 300
    press_space();
    press_space();
    play_round(300); press_space();
    play_round(300); press_space();
    tick();
    press_space();
    chk("foul_screen", int'(oScreen), 4);
    chk("foul_count", int'(oFouls), 1);
    chk("foul_round", int'(oRound), 2);
    press_space();
    chk("foul_retry_screen", int'(oScreen), 1);
    chk("foul_retry_round", int'(oRound), 2);
    play_round(300); press_space();
    play_round(300); press_space();
    play_round(300); press_space();
    wait_average("foul");
    chk("foul_avg", int'(oAverage), 300);

    // Timeout, then abort in DIV
    press_space();
    press_space();
    tick();
    iCountComplete = 1'b1; tick(); iCountComplete = 1'b0;
    iRoundScore = 998; tick();
    chk("to_hold_go", int'(oScreen), 2);
    chk("to_no_load", int'(oLoadScore), 0);
    iRoundScore = 999; tick();
    chk("to_load", int'(oLoadScore), 1);
    tick();
    chk("to_best", int'(oBest), 999);
    iRoundScore = '0;
    for (int r = 1; r < 5; r++) begin
      press_space();
      play_round(100);
    end
    chk("to_best_min", int'(oBest), 100);
    press_space();
    tick(); tick(); tick();
    iOnePressed = 1'b1; tick(); iOnePressed = 1'b0;
    chk("abort_screen", int'(oScreen), 0);
    chk("abort_valid", int'(oValid), 0);
    for (int i = 0; i < SUM_W + 3; i++) tick();
    chk("abort_late_valid", int'(oValid), 0);
    chk("abort_late_screen", int'(oScreen), 0);
    press_space();
    chk("restart_screen", int'(oScreen), 1);
    chk("restart_round", int'(oRound), 0);
    chk("restart_fouls", int'(oFouls), 0);
    chk("restart_best", int'(oBest), 0);

    // Reset while in GO
    tick();
    iCountComplete = 1'b1; tick(); iCountComplete = 1'b0;
    chk("pre_rst_go", int'(oScreen), 2);
    #2 iResetn = 1'b0;
    #1;
    chk("async_rst_screen", int'(oScreen), 0);
    chk("async_rst_dload", int'(oDelayLoad), 0);
    chk("async_rst_up", int'(oStartUpCount), 0);
    iSpacePressed = 1'b1;
    tick();
    chk("rst_low_no_load", int'(oLoadScore), 0);
    chk("rst_low_screen", int'(oScreen), 0);
    iSpacePressed = 1'b0;
    iResetn = 1'b1;
    tick();
    chk("post_rst_idle", int'(oScreen), 0);
    iPrng = 8'h3C;
    press_space();
    chk("post_rst_arm", int'(oScreen), 1);
    tick();
    chk("post_rst_dload", int'(oDelayLoad), 8'h3C);
    chk("post_rst_down", int'(oStartDownCount), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reaction_session_ctrl.md
# reaction_session_ctrl

Multi-round session controller for the reaction-time benchmark. It sequences the reaction datapath (random-delay down-counter, elapsed-time up-counter, score latch) through NUM_ROUNDS trials. It detects false starts and keeps the session best, then computes the truncated average with a sequential divider. It sits between the keyboard decoder/PRNG and the reaction datapath, and drives the screen selector for the VGA renderer.

## Interface
Parameters:
- NUM_ROUNDS, 5: trials per session (2..7)
- SCORE_W, 12: score width in ms
- TIMEOUT_MS, 999: score at which an unanswered GO is forced to end

Ports:
- clk  in  1  system clock
- iResetn  in  1  reset, asynchronous, active-low
- iSpacePressed  in  1  one-cycle pulse per space keypress
- iOnePressed  in  1  one-cycle pulse; abort to menu
- iPrng  in  8  PRNG output
- iCountComplete  in  1  datapath random delay elapsed (level)
- iRoundScore  in  SCORE_W  datapath elapsed/latched ms
- oDelayLoad  out  8  delay seed captured for the datapath
- oStartDownCount  out  1  pulse: start the random delay
- oStartUpCount  out  1  pulse: start the reaction timer
- oLoadScore  out  1  pulse: datapath latches the score
- oScreen  out  3  0 MENU, 1 WAIT, 2 GO, 3 RESULT, 4 FOUL, 5 SUMMARY
- oRound  out  3  current round index, 0-based
- oFouls  out  4  false starts this session, saturating at 15
- oBest  out  SCORE_W  lowest round score this session
- oAverage  out  SCORE_W  sum / NUM_ROUNDS, truncated
- oValid  out  1  oAverage holds this session's result

## Operation
States: IDLE, ARM, WAIT, GO, CAPTURE, RESULT, FOUL, DIV, SUMMARY.

- **IDLE** (MENU): on space, clear the sum, oRound, oFouls, oBest and oValid, then go to ARM.
- **ARM** (WAIT screen): lasts one cycle. Register iPrng into oDelayLoad, pulse oStartDownCount, go to WAIT.
- **WAIT**: space goes to FOUL. Otherwise iCountComplete pulses oStartUpCount and goes to GO. When both occur in the same cycle, FOUL wins.
- **GO**: space pulses oLoadScore and goes to CAPTURE. If iRoundScore ≥ TIMEOUT_MS, pulse oLoadScore and go to CAPTURE anyway.
- **CAPTURE**: lasts one cycle.
  - Sample iRoundScore, clamped to TIMEOUT_MS.
  - Add the sample to the sum.
  - oBest is set to the sample on round 0; on later rounds it becomes min(oBest, sample).
  - Go to RESULT.
- **RESULT**: on space:
  - if oRound == NUM_ROUNDS-1, go to DIV;
  - otherwise increment oRound and go to ARM.
- **FOUL**: increment oFouls (saturating) once, on entry. Space goes to ARM for the same round; oRound is unchanged and the sum is unchanged.
- **DIV**: pulse the divider start on entry. On divider done, register the quotient into oAverage, set oValid, go to SUMMARY.
- **SUMMARY**: space or one goes to IDLE. oAverage, oBest and oValid hold until the next session start.
- **Abort**: iOnePressed in ARM, WAIT, GO, CAPTURE, RESULT, FOUL or DIV goes to IDLE.
  - No score is committed.
  - oValid stays 0.
  - A divider in flight is discarded.
- Space presses in CAPTURE and DIV are ignored.

Arithmetic:
- The sum is SUM_W = SCORE_W + 3 bits wide and cannot overflow.
- The quotient fits in SCORE_W bits because every sample is at most TIMEOUT_MS.

## Timing
- Reset state: IDLE, with every output 0.
- All outputs are registered.
- Pulse outputs are exactly one cycle wide and coincide with the registered state transition.
- Every input event has 1-cycle latency: the next state, and any pulse, appear the cycle after the input is sampled.
- Score: the datapath holds iRoundScore valid in the cycle after oLoadScore, which is the CAPTURE cycle.
- Divider: one quotient bit per cycle, SUM_W cycles. oValid and oAverage rise SUM_W+1 cycles after DIV entry.
- Reset asserted mid-session: all state clears asynchronously. There are no pulses while reset is low.

## Structure
- Package `reaction_pkg` holds:
  - the state encoding;
  - the screen codes (SCR_MENU … SCR_SUMMARY);
  - the SUM_W derivation.

  The screen codes are shared with the datapath and the renderer.
- Sub-module `seq_divider` holds the restoring divider.
  - Parameters: dividend width and divisor width.
  - Ports: start, dividend, divisor, quotient, done.
  - Control signals are active-high; reset is the same iResetn.
- The controller holds the FSM, accumulators and output registers.

## Test plan
- **Clean session:** reset, then space. Play 5 rounds scoring 200, 250, 300, 180, 220 ms. Expected: oBest=180, oAverage=230, oValid high SUM_W+1 cycles after the final space, oScreen=5.
- **False start:** press space in WAIT during round 2. Expected: oScreen=4, oFouls=1, oRound stays 2, sum unchanged. Space retries; after rounds of 300 ms each, oAverage=300.
- **Simultaneous events:** space and iCountComplete in the same cycle. Expected: FOUL, with no oStartUpCount pulse.
- **Timeout:** no press in GO. Expected: when iRoundScore reaches 999, oLoadScore pulses and a sample of 999 is recorded. iRoundScore=1200 presented in CAPTURE clamps to 999.
- **Abort:** one pressed during DIV. Expected: IDLE next cycle, oValid stays 0, no late oAverage update. A following session starts cleared.
- **Reset mid-GO:** assert iResetn low. Expected: all outputs 0 immediately. After release, IDLE, and the first space produces ARM with oDelayLoad = iPrng.
